// File: rtl/recorder_player_sequencer.sv
// Command-driven sequencer for the stream recorder/player: drives the record/play levels,
// watches the tapped stream handshakes for frame ends and reports done/err plus status counters.
module recorder_player_sequencer #(
  parameter int unsigned REPEAT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [REPEAT_WIDTH-1:0] cmd_repeat,
  input  logic                    abort,
  input  logic                    in_valid,
  input  logic                    in_ready,
  input  logic                    in_last,
  input  logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    out_last,
  output logic                    record,
  output logic                    play,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err,
  output logic [CNT_WIDTH-1:0]    beats_captured,
  output logic [REPEAT_WIDTH-1:0] replays_done
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [2:0] {S_IDLE, S_REC, S_REC_END, S_GAP, S_PLAY} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_CAPTURE, OP_REPLAY, OP_CAP_REPLAY} op_t;
  typedef enum logic [1:0] {ERR_OK, ERR_CAP_TMO, ERR_PLAY_TMO, ERR_ABORT} err_t;

  state_t                  state, state_n;
  op_t                     op_q, op_n;
  err_t                    err_q, err_n;
  logic [REPEAT_WIDTH-1:0] rep_q, rep_n;
  logic [GW-1:0]           gcnt, gcnt_n;
  logic [TW-1:0]           tcnt, tcnt_n;
  logic [CNT_WIDTH-1:0]    beats_n;
  logic [REPEAT_WIDTH-1:0] replays_n;
  logic                    done_n;
  logic                    accept, in_hs, out_hs, tmo_hit;

  assign cmd_ready = (state == S_IDLE) & ~abort;
  assign accept    = cmd_valid & cmd_ready;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign err       = err_q;

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    rep_n     = rep_q;
    gcnt_n    = gcnt;
    tcnt_n    = tcnt;
    beats_n   = beats_captured;
    replays_n = replays_done;
    err_n     = err_q;
    done_n    = 1'b0;
    tmo_hit   = TMO_EN && (tcnt == TMO_LAST);

    // Abort outranks any same-cycle frame end or timeout, so it is resolved before the state case.
    if (state != S_IDLE && abort) begin
      state_n = S_IDLE;
      done_n  = 1'b1;
      err_n   = ERR_ABORT;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept && cmd_op != 2'd0) begin
            op_n      = op_t'(cmd_op);
            rep_n     = cmd_repeat;
            err_n     = ERR_OK;
            replays_n = '0;
            if (op_t'(cmd_op) == OP_REPLAY) begin
              state_n = S_GAP;
              gcnt_n  = '0;
            end else begin
              state_n = S_REC;
              tcnt_n  = '0;
              beats_n = '0;
            end
          end
        end
        S_REC: begin
          if (in_hs) begin
            if (beats_captured != '1) beats_n = beats_captured + CNT_WIDTH'(1);
            tcnt_n = '0;
            if (in_last) state_n = S_REC_END;
          end else if (tmo_hit) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            err_n   = ERR_CAP_TMO;
          end else if (TMO_EN) begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        S_REC_END: begin
          if (op_q == OP_CAPTURE) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            err_n   = ERR_OK;
          end else begin
            state_n = S_GAP;
            gcnt_n  = '0;
          end
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) begin
            state_n = S_PLAY;
            tcnt_n  = '0;
          end else begin
            gcnt_n = gcnt + GW'(1);
          end
        end
        S_PLAY: begin
          if (out_hs) begin
            tcnt_n = '0;
            if (out_last) begin
              replays_n = replays_done + REPEAT_WIDTH'(1);
              if (rep_q != '0 && replays_n == rep_q) begin
                state_n = S_IDLE;
                done_n  = 1'b1;
                err_n   = ERR_OK;
              end else begin
                state_n = S_GAP;
                gcnt_n  = '0;
              end
            end
          end else if (tmo_hit) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            err_n   = ERR_PLAY_TMO;
          end else if (TMO_EN) begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      op_q           <= OP_NOP;
      rep_q          <= '0;
      gcnt           <= '0;
      tcnt           <= '0;
      beats_captured <= '0;
      replays_done   <= '0;
      err_q          <= ERR_OK;
      done           <= 1'b0;
      record         <= 1'b0;
      play           <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      op_q           <= op_n;
      rep_q          <= rep_n;
      gcnt           <= gcnt_n;
      tcnt           <= tcnt_n;
      beats_captured <= beats_n;
      replays_done   <= replays_n;
      err_q          <= err_n;
      done           <= done_n;
      record         <= (state_n == S_REC);
      play           <= (state_n == S_PLAY);
      busy           <= (state_n != S_IDLE);
    end
  end

endmodule
